// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding and the grant identity used by the
// round-robin tie-break.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-line request bus: one requester (master) and one responder (slave).
// Signals: read/write strobes, line address, write line, read line, resp pulse.
// master drives the request fields; slave returns rdata and the resp pulse.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output read, write, address, wdata, input rdata, resp);
    modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates I-side reads and D-side reads/writes onto one memory port, round-robin on conflict.
// Latency: request to memory strobe 1 cycle; memory resp to requester resp 0 cycles; one idle cycle between transactions.
// Backpressure: requesters hold their request until resp; memory stalls by delaying m_resp, strobes stay held meanwhile.
// Ports: clk, rst_n (async, active-low); i_bus (slave, read-only side, write/wdata ignored);
//        d_bus (slave, read/write side); m_bus (master, towards physical memory).
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  i_bus,
    mem_arbiter_if.slave  d_bus,
    mem_arbiter_if.master m_bus
);

    arb_state_t        state;
    grant_t            last_grant;
    grant_t            pick;
    logic              i_req;
    logic              d_req;
    logic              op_read;
    logic              op_write;
    logic [ADDR_W-1:0] op_addr;
    logic [LINE_W-1:0] op_wdata;

    // The instruction side never writes; its write fields are tied off here.
    logic unused_i_side;
    assign unused_i_side = ^{i_bus.write, i_bus.wdata};

    // Winner selection: on conflict the side that did not win last time goes.
    always_comb begin
        i_req = i_bus.read;
        d_req = d_bus.read | d_bus.write;
        pick  = GRANT_I;
        if (i_req && d_req) begin
            pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            pick = GRANT_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            op_read    <= 1'b0;
            op_write   <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (pick == GRANT_D) begin
                            state    <= SERVE_D;
                            op_addr  <= d_bus.address;
                            op_wdata <= d_bus.wdata;
                            // read+write together is treated as a write
                            op_write <= d_bus.write;
                            op_read  <= ~d_bus.write;
                        end else begin
                            state    <= SERVE_I;
                            op_addr  <= i_bus.address;
                            op_wdata <= '0;
                            op_write <= 1'b0;
                            op_read  <= 1'b1;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester inputs are not looked at here, so a dropped
                    // request still runs to completion.
                    if (m_bus.resp) begin
                        state      <= IDLE;
                        last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
                        op_read    <= 1'b0;
                        op_write   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory request comes only from the latched registers.
    assign m_bus.read    = op_read;
    assign m_bus.write   = op_write;
    assign m_bus.address = op_addr;
    assign m_bus.wdata   = op_wdata;

    // Completion is a same-cycle pass-through; rdata is only meaningful with resp.
    assign i_bus.rdata = m_bus.rdata;
    assign d_bus.rdata = m_bus.rdata;
    assign i_bus.resp  = (state == SERVE_I) && m_bus.resp;
    assign d_bus.resp  = (state == SERVE_D) && m_bus.resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model (who wins, what the memory sees,
// which side completes).
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) m_bus ();

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_bus (i_bus),
        .d_bus (d_bus),
        .m_bus (m_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    // Model state: side that completed most recently (0 = I, 1 = D).
    int exp_last    = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic clear_reqs();
        i_bus.read = 1'b0;
        d_bus.read = 1'b0;
        d_bus.write = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mread"}, m_bus.read, 1'b0);
        chk({tag, "_mwrite"}, m_bus.write, 1'b0);
        chk({tag, "_iresp"}, i_bus.resp, 1'b0);
        chk({tag, "_dresp"}, d_bus.resp, 1'b0);
    endtask

    task automatic do_reset();
        clear_reqs();
        m_bus.resp = 1'b0;
        rst_n = 1'b0;
        #1;
        check_quiet("rst");
        chk("rst_maddr", m_bus.address, '0);
        chk("rst_mwdata", m_bus.wdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_last = 0;
    endtask

    // Runs one transaction from the currently presented requests. Call during
    // an idle cycle before its sampling edge; returns at the negedge of the
    // idle cycle that follows completion.
    task automatic txn(input int lat, input bit drop, output int obs_w);
        int                w;
        bit                ir, dr, ew;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ed, rd;
        ir = i_bus.read;
        dr = d_bus.read | d_bus.write;
        if (ir && dr) w = (exp_last == 0) ? 1 : 0;
        else          w = dr ? 1 : 0;
        ea = (w == 1) ? d_bus.address : i_bus.address;
        ew = (w == 1) && d_bus.write;
        ed = d_bus.wdata;
        @(posedge clk); #1;
        if (drop) clear_reqs();
        repeat (lat) begin
            @(negedge clk);
            chk("wait_mread", m_bus.read, !ew);
            chk("wait_mwrite", m_bus.write, ew);
            chk("wait_maddr", m_bus.address, ea);
            if (ew) chk("wait_mwdata", m_bus.wdata, ed);
            chk("wait_overlap", m_bus.read & m_bus.write, 1'b0);
            chk("wait_iresp", i_bus.resp, 1'b0);
            chk("wait_dresp", d_bus.resp, 1'b0);
            @(posedge clk); #1;
        end
        rd = rand_line();
        m_bus.rdata = rd;
        m_bus.resp = 1'b1;
        @(negedge clk);
        chk("resp_mread", m_bus.read, !ew);
        chk("resp_mwrite", m_bus.write, ew);
        chk("resp_maddr", m_bus.address, ea);
        obs_w = d_bus.resp ? 1 : (i_bus.resp ? 0 : -1);
        chk("grant", obs_w, w);
        chk("resp_iresp", i_bus.resp, w == 0);
        chk("resp_dresp", d_bus.resp, w == 1);
        if (w == 1) chk("d_rdata", d_bus.rdata, rd);
        else        chk("i_rdata", i_bus.rdata, rd);
        @(posedge clk); #1;
        m_bus.resp = 1'b0;
        exp_last = w;
        @(negedge clk);
        check_quiet("gap");
    endtask

    initial begin
        int obs;
        int order[4];
        int pat, op;
        rst_n = 1'b1;
        clear_reqs();
        i_bus.write = 1'b0;
        i_bus.wdata = '0;
        i_bus.address = '0;
        d_bus.address = '0;
        d_bus.wdata = '0;
        m_bus.resp = 1'b0;
        m_bus.rdata = '0;
        #2;
        do_reset();

        // Single instruction read, memory answers after 5 cycles.
        i_bus.read = 1'b1;
        i_bus.address = 32'h0000_0040;
        txn(5, 1'b0, obs);
        clear_reqs();
        @(negedge clk);
        check_quiet("idle_after_i");

        // Simultaneous requests straight after reset: data wins, then instruction.
        do_reset();
        i_bus.read = 1'b1;
        i_bus.address = 32'h0000_0080;
        d_bus.write = 1'b1;
        d_bus.address = 32'h0000_0100;
        d_bus.wdata = rand_line();
        txn(2, 1'b0, obs);
        chk("first_conflict_d", obs, 1);
        d_bus.write = 1'b0;
        txn(1, 1'b0, obs);
        chk("then_i", obs, 0);
        clear_reqs();

        // Continuous contention: expect D, I, D, I.
        do_reset();
        i_bus.read = 1'b1;
        d_bus.read = 1'b1;
        d_bus.address = 32'h0000_0300;
        for (int t = 0; t < 4; t++) begin
            txn($urandom_range(0, 3), 1'b0, obs);
            order[t] = obs;
        end
        chk("rr0", order[0], 1);
        chk("rr1", order[1], 0);
        chk("rr2", order[2], 1);
        chk("rr3", order[3], 0);
        clear_reqs();

        // Read and write together: treated as a write.
        d_bus.read = 1'b1;
        d_bus.write = 1'b1;
        d_bus.address = 32'h0000_0200;
        d_bus.wdata = rand_line();
        txn(3, 1'b1, obs);
        clear_reqs();

        // Reset two cycles into an instruction read.
        i_bus.read = 1'b1;
        i_bus.address = 32'h0000_0440;
        @(posedge clk); #1;
        i_bus.read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_mread", m_bus.read, 1'b1);
        rst_n = 1'b0;
        m_bus.resp = 1'b1;
        #1;
        chk("midrst_mread", m_bus.read, 1'b0);
        chk("midrst_iresp", i_bus.resp, 1'b0);
        chk("midrst_maddr", m_bus.address, '0);
        @(negedge clk);
        m_bus.resp = 1'b0;
        rst_n = 1'b1;
        exp_last = 0;
        repeat (2) begin
            @(negedge clk);
            check_quiet("post_rst");
        end
        i_bus.read = 1'b1;
        d_bus.read = 1'b1;
        txn(0, 1'b1, obs);
        chk("post_rst_conflict_d", obs, 1);

        // Stray m_resp while idle.
        @(posedge clk); #1;
        m_bus.resp = 1'b1;
        m_bus.rdata = rand_line();
        @(negedge clk);
        check_quiet("stray");
        @(posedge clk); #1;
        m_bus.resp = 1'b0;
        @(negedge clk);
        check_quiet("stray_after");

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            pat = $urandom_range(1, 3);
            i_bus.read = pat[0];
            i_bus.address = $urandom() & 32'hFFFF_FFE0;
            op = pat[1] ? $urandom_range(1, 3) : 0;
            d_bus.read = op[0];
            d_bus.write = op[1];
            d_bus.address = $urandom() & 32'hFFFF_FFE0;
            d_bus.wdata = rand_line();
            txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), obs);
        end
        clear_reqs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: LINE_W, 256, cache-line width in bits.
REQ-002 SHALL have parameter: ADDR_W, 32, byte-address width.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports: i_read  in  1  instruction-side line read request.
REQ-006 SHALL have ports: i_address  in  ADDR_W  instruction-side line address.
REQ-007 SHALL have ports: i_rdata  out  LINE_W  instruction-side read line.
REQ-008 SHALL have ports: i_resp  out  1  instruction-side completion pulse.
REQ-009 SHALL have ports: d_read, d_write  in  1 each  data-side line read/write request.
REQ-010 SHALL have ports: d_address  in  ADDR_W  data-side line address.
REQ-011 SHALL have ports: d_wdata  in  LINE_W  data-side write line.
REQ-012 SHALL have ports: d_rdata  out  LINE_W, d_resp  out  1  data-side read line and completion pulse.
REQ-013 SHALL have ports: m_read, m_write  out  1 each  physical-memory read/write strobes.
REQ-014 SHALL have ports: m_address  out  ADDR_W, m_wdata  out  LINE_W  physical-memory request.
REQ-015 SHALL have ports: m_rdata  in  LINE_W, m_resp  in  1  physical-memory read line and completion.

Function
REQ-016 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-017 SHALL, in IDLE, drive m_read=m_write=0 and ignore m_resp.
REQ-018 SHALL, in IDLE with only i_read set, enter SERVE_I next edge.
REQ-019 SHALL, in IDLE with only a data request (d_read|d_write) set, enter SERVE_D next edge.
REQ-020 SHALL, in IDLE with both sides requesting, grant the side not granted last (round-robin via last_grant register).
REQ-021 SHALL, on the entry edge, latch the winner's address, wdata and op into internal registers; m_* outputs come only from these registers.
REQ-022 SHALL treat d_read&d_write together as a write (d_write precedence).
REQ-023 SHALL hold m_read/m_write asserted throughout SERVE_x until m_resp.
REQ-024 SHALL, on m_resp in SERVE_x, pulse x_resp high for exactly that cycle, pass m_rdata combinationally to x_rdata, update last_grant=x, return to IDLE.
REQ-025 SHALL keep the non-granted side's resp at 0; x_rdata may be don't-care outside its resp cycle.
REQ-026 SHALL complete a granted transaction even if the requester deasserts mid-transaction.
REQ-027 SHALL insert one IDLE cycle between consecutive transactions; request-to-strobe latency 1 cycle, m_resp-to-x_resp latency 0.
REQ-028 SHALL never assert m_read and m_write together.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state=IDLE, last_grant=I (data wins first conflict), latched registers=0.
REQ-030 SHALL during reset drive m_read=m_write=i_resp=d_resp=0, m_address=0, m_wdata=0.
REQ-031 SHALL abandon an in-flight transaction on reset mid-operation without a resp pulse.

Structure
REQ-032 SHALL place state enum (arb_state_t) and grant enum (grant_t: GRANT_I, GRANT_D) in a shared package arbiter_types.
REQ-033 SHALL be a single module; no sub-module needed.

Verification
REQ-034 SHALL cover: i_read, i_address=0x0000_0040, m_resp after 5 cycles, m_rdata=0xA5..A5 -> m_read from cycle 1, m_address=0x40, i_resp one cycle with i_rdata=0xA5..A5.
REQ-035 SHALL cover: i_read and d_write same cycle after reset, d_address=0x100 -> SERVE_D first (m_write, m_wdata=d_wdata), then SERVE_I after one IDLE.
REQ-036 SHALL cover: both sides requesting continuously for 4 transactions -> grant order D,I,D,I, no m_read&m_write overlap.
REQ-037 SHALL cover: d_read&d_write both set, d_address=0x200 -> m_write=1, m_read=0, d_resp on m_resp.
REQ-038 SHALL cover: rst_n low 2 cycles into SERVE_I -> m_read drops immediately, no i_resp, state IDLE after release.
REQ-039 SHALL cover: m_resp pulsed in IDLE -> no i_resp/d_resp, state stays IDLE.
